// File: rtl/crc_byte_sequencer.sv
// -----------------------------------------------------------------------------
// crc_byte_sequencer
//
// Byte-serial CRC engine with run-time configurable width (8/16/32 bits),
// polynomial, initial value, final XOR and input/output reflection. Each
// message byte is folded into the CRC register one bit per clock, so a byte
// costs one ACCEPT cycle plus eight SHIFT cycles (9 cycles per byte at full
// throughput). After the byte flagged as last, one FINAL cycle produces the
// result and one DONE cycle returns the sequencer to IDLE.
//
// Ports
//   clk          : clock, rising edge active
//   rst_n        : asynchronous active-low reset
//   start        : begin a message (honoured only in IDLE)
//   cfg_width    : 0 = CRC-8, 1 = CRC-16, 2/3 = CRC-32
//   cfg_poly     : generator polynomial, normal form, implicit top bit omitted
//   cfg_init     : initial CRC register value
//   cfg_xorout   : value XORed into the final result
//   cfg_refin    : 1 = bytes are processed LSB first
//   cfg_refout   : 1 = final register is reflected across W bits
//   in_valid     : in_data / in_last are valid
//   in_data      : message byte
//   in_last      : marks the final byte of the message
//   in_ready     : high only while waiting for a byte (ACCEPT)
//   busy         : high whenever the sequencer is not IDLE
//   crc_valid    : one-cycle pulse when crc_out is updated
//   crc_out      : final CRC, bits above W are zero, held until next result
// -----------------------------------------------------------------------------
module crc_byte_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  cfg_width,
  input  logic [31:0] cfg_poly,
  input  logic [31:0] cfg_init,
  input  logic [31:0] cfg_xorout,
  input  logic        cfg_refin,
  input  logic        cfg_refout,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        crc_valid,
  output logic [31:0] crc_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_SHIFT  = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Mask selecting the active W low bits of a 32-bit word.
  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Bit W-1 of the register, i.e. the coefficient that leaves on the next shift.
  function automatic logic top_bit(input logic [31:0] v, input logic [1:0] w);
    case (w)
      2'd0:    return v[7];
      2'd1:    return v[15];
      default: return v[31];
    endcase
  endfunction

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reflect across W bits: a full 32-bit reversal parks the W-bit field at the
  // top of the word, so shift it back down by 32-W.
  function automatic logic [31:0] reflect_w(input logic [31:0] v, input logic [1:0] w);
    logic [31:0] r;
    r = reflect32(v);
    case (w)
      2'd0:    return r >> 24;
      2'd1:    return r >> 16;
      default: return r;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and configuration registers
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [1:0]  width_q;
  logic [31:0] poly_q;     // stored pre-masked to W
  logic [31:0] xorout_q;   // stored pre-masked to W
  logic        refin_q;
  logic        refout_q;
  logic [31:0] crc_q;      // bits above W always zero
  logic [7:0]  byte_q;     // shifted left each SHIFT cycle, bit 7 is the next bit
  logic        last_q;
  logic [2:0]  bitcnt_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        crc_valid_q;
  logic [31:0] crc_out_q;

  // ---------------------------------------------------------------------------
  // Datapath: one LFSR step and the final result
  // ---------------------------------------------------------------------------
  logic [31:0] mask_d;
  logic        fb_d;
  logic [31:0] crc_d;
  logic [31:0] result_d;

  always_comb begin
    mask_d   = width_mask(width_q);
    fb_d     = top_bit(crc_q, width_q) ^ byte_q[7];
    crc_d    = ((crc_q << 1) & mask_d) ^ (fb_d ? poly_q : 32'd0);
    result_d = ((refout_q ? reflect_w(crc_q, width_q) : crc_q) ^ xorout_q) & mask_d;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      width_q     <= 2'd0;
      poly_q      <= 32'd0;
      xorout_q    <= 32'd0;
      refin_q     <= 1'b0;
      refout_q    <= 1'b0;
      crc_q       <= 32'd0;
      byte_q      <= 8'd0;
      last_q      <= 1'b0;
      bitcnt_q    <= 3'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_out_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Configuration is frozen here for the whole message.
            width_q    <= cfg_width;
            poly_q     <= cfg_poly   & width_mask(cfg_width);
            xorout_q   <= cfg_xorout & width_mask(cfg_width);
            refin_q    <= cfg_refin;
            refout_q   <= cfg_refout;
            crc_q      <= cfg_init   & width_mask(cfg_width);
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCEPT;
          end
        end

        S_ACCEPT: begin
          if (in_valid) begin
            // Reflecting the byte up front lets SHIFT always consume MSB first.
            byte_q     <= cfg_byte(in_data);
            last_q     <= in_last;
            bitcnt_q   <= 3'd0;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          crc_q    <= crc_d;
          byte_q   <= byte_q << 1;
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (last_q) begin
              state_q <= S_FINAL;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_ACCEPT;
            end
          end
        end

        S_FINAL: begin
          crc_out_q   <= result_d;
          crc_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end

        S_DONE: begin
          // start is deliberately not looked at here: one idle cycle between messages.
          crc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          crc_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Byte as it enters the shift register (reflected when LSB-first input).
  function automatic logic [7:0] cfg_byte(input logic [7:0] d);
    return refin_q ? reflect8(d) : d;
  endfunction

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;

endmodule

// File: tb/tb_crc_byte_sequencer.sv
module tb_crc_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cfg_width;
  logic [31:0] cfg_poly;
  logic [31:0] cfg_init;
  logic [31:0] cfg_xorout;
  logic        cfg_refin;
  logic        cfg_refout;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        busy;
  logic        crc_valid;
  logic [31:0] crc_out;

  crc_byte_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_poly   (cfg_poly),
    .cfg_init   (cfg_init),
    .cfg_xorout (cfg_xorout),
    .cfg_refin  (cfg_refin),
    .cfg_refout (cfg_refout),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .busy       (busy),
    .crc_valid  (crc_valid),
    .crc_out    (crc_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [1:0]  w;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xo;
    bit          ri;
    bit          ro;
    int          msel;   // 0 = "123456789", 1 = single byte 0x01
    bit          gaps;   // random in_valid gaps
    bit          noisy;  // start pulses and cfg changes during the message
    logic [31:0] exp;
  } vec_t;

  logic [7:0] msg_b [0:63];
  int         msg_len;

  function automatic vec_t mk(string n, logic [1:0] w, logic [31:0] poly, logic [31:0] init,
                              logic [31:0] xo, bit ri, bit ro, int msel, bit gaps, bit noisy,
                              logic [31:0] exp);
    vec_t v;
    v.name = n; v.w = w; v.poly = poly; v.init = init; v.xo = xo;
    v.ri = ri; v.ro = ro; v.msel = msel; v.gaps = gaps; v.noisy = noisy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: CRC as the remainder of (M(x)*x^W + INIT(x)*x^L) mod P(x),
  // computed by long division over an explicit coefficient array.
  function automatic logic [31:0] model_crc(input logic [1:0] wc, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit ri, input bit ro, input int len);
    bit          a [0:511];
    int          W;
    int          L;
    logic [31:0] rem;
    logic [31:0] res;
    W = (wc == 2'd0) ? 8 : (wc == 2'd1) ? 16 : 32;
    L = len * 8;
    for (int i = 0; i < 512; i++) a[i] = 1'b0;
    for (int n = 0; n < len; n++)
      for (int b = 0; b < 8; b++)
        a[L - 1 - (n * 8 + b) + W] ^= (ri ? msg_b[n][b] : msg_b[n][7 - b]);
    for (int j = 0; j < W; j++) a[L + j] ^= init[j];
    for (int i = L + W - 1; i >= W; i--)
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 0; j < W; j++) a[i - W + j] ^= poly[j];
      end
    rem = 32'd0;
    for (int j = 0; j < W; j++) rem[j] = a[j];
    res = 32'd0;
    for (int j = 0; j < W; j++) res[j] = (ro ? rem[W - 1 - j] : rem[j]) ^ xo[j];
    return res;
  endfunction

  task automatic load_msg(input int msel);
    if (msel == 1) begin
      msg_b[0] = 8'h01;
      msg_len  = 1;
    end else begin
      for (int i = 0; i < 9; i++) msg_b[i] = 8'h31 + 8'(i);
      msg_len = 9;
    end
  endtask

  task automatic noise();
    start      = 1'($urandom_range(0, 1));
    cfg_width  = 2'($urandom);
    cfg_poly   = $urandom;
    cfg_init   = $urandom;
    cfg_xorout = $urandom;
    cfg_refin  = 1'($urandom_range(0, 1));
    cfg_refout = 1'($urandom_range(0, 1));
  endtask

  task automatic run_msg(input vec_t v, input int len);
    int unsigned ea;
    int unsigned prev;
    bit          rdy;
    int          guard;
    cfg_width = v.w; cfg_poly = v.poly; cfg_init = v.init; cfg_xorout = v.xo;
    cfg_refin = v.ri; cfg_refout = v.ro;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, " ready_after_start"}, {31'd0, in_ready}, 32'd1);
    prev = 0;
    ea   = cyc;
    for (int i = 0; i < len; i++) begin
      in_data = msg_b[i];
      in_last = (i == len - 1);
      guard   = 0;
      forever begin
        in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (v.noisy) noise();
        rdy = in_ready;
        @(posedge clk); #1;
        guard++;
        if (rdy && in_valid) break;
        if (guard > 100) break;
      end
      if (guard > 100) begin
        chk({v.name, " accept_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      ea = cyc;
      if (i > 0) begin
        if (v.gaps) chk({v.name, " ready_spacing_ge9"}, {31'd0, (ea - prev) >= 9}, 32'd1);
        else        chk({v.name, " ready_spacing_eq9"}, ea - prev, 32'd9);
      end
      prev = ea;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    guard    = 0;
    while (!crc_valid && guard < 40) begin
      if (v.noisy) noise();
      @(posedge clk); #1;
      guard++;
    end
    chk({v.name, " valid_latency"}, cyc - ea, 32'd9);
    chk({v.name, " crc_out"}, crc_out, v.exp);
    chk({v.name, " busy_in_pulse"}, {31'd0, busy}, 32'd1);
    if (v.noisy) begin
      noise();
      start = 1'b1;   // start while in DONE must not be honoured
    end else begin
      start = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, " valid_one_cycle"}, {31'd0, crc_valid}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, " busy_idle"}, {31'd0, busy}, 32'd0);
    chk({v.name, " crc_out_held"}, crc_out, v.exp);
  endtask

  vec_t vt [8];

  initial begin
    #900000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   len;

    vt[0] = mk("crc8",        2'd0, 32'h0000_0007, 32'h0,          32'h0,          0, 0, 0, 0, 0, 32'h0000_00F4);
    vt[1] = mk("crc16_ccitt", 2'd1, 32'h0000_1021, 32'h0000_FFFF,  32'h0,          0, 0, 0, 0, 0, 32'h0000_29B1);
    vt[2] = mk("crc16_arc",   2'd1, 32'h0000_8005, 32'h0,          32'h0,          1, 1, 0, 0, 0, 32'h0000_BB3D);
    vt[3] = mk("crc32_gaps",  2'd2, 32'h04C1_1DB7, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 1, 0, 1, 0, 32'hCBF4_3926);
    vt[4] = mk("crc32_w3",    2'd3, 32'h04C1_1DB7, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 1, 0, 0, 0, 32'hCBF4_3926);
    vt[5] = mk("crc8_onebyte",2'd0, 32'h0000_0007, 32'h0,          32'h0,          0, 0, 1, 0, 0, 32'h0000_0007);
    vt[6] = mk("crc8_himask", 2'd0, 32'hABCD_EF07, 32'hFFFF_FF00,  32'h55AA_0000,  0, 0, 0, 0, 0, 32'h0000_00F4);
    vt[7] = mk("crc8_noisy",  2'd0, 32'h0000_0007, 32'h0,          32'h0,          0, 0, 0, 1, 1, 32'h0000_00F4);

    rst_n = 1'b0; start = 1'b0; cfg_width = 2'd0; cfg_poly = 32'd0; cfg_init = 32'd0;
    cfg_xorout = 32'd0; cfg_refin = 1'b0; cfg_refout = 1'b0;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  {31'd0, in_ready},  32'd0);
    chk("reset busy",      {31'd0, busy},      32'd0);
    chk("reset crc_valid", {31'd0, crc_valid}, 32'd0);
    chk("reset crc_out",   crc_out,            32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load_msg(vt[i].msel);
      run_msg(vt[i], msg_len);
    end

    // Reset during the 4th SHIFT cycle of the first byte.
    load_msg(0);
    cfg_width = 2'd0; cfg_poly = 32'h07; cfg_init = 32'h0; cfg_xorout = 32'h0;
    cfg_refin = 1'b0; cfg_refout = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = msg_b[0]; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready",  {31'd0, in_ready},  32'd0);
    chk("midreset busy",      {31'd0, busy},      32'd0);
    chk("midreset crc_valid", {31'd0, crc_valid}, 32'd0);
    chk("midreset crc_out",   crc_out,            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h31; in_last = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("postreset needs_start busy",     {31'd0, busy},      32'd0);
    chk("postreset needs_start in_ready", {31'd0, in_ready},  32'd0);
    chk("postreset needs_start crc_out",  crc_out,            32'd0);
    run_msg(vt[0], 9);

    // Randomized messages against the long-division reference.
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) msg_b[i] = 8'($urandom);
      rv = mk("rand", 2'($urandom), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
              1'($urandom_range(0, 1)), 0, 32'd0);
      rv.exp = model_crc(rv.w, rv.poly, rv.init, rv.xo, rv.ri, rv.ro, len);
      run_msg(rv, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
